dram_responder: RTL and testbench

Synthesizable off-chip memory responder: the memory side of the accelerator's DRAM read/write interface.
- Accepts one write and one read request per cycle.
- Returns read data with a fixed, parameterised latency and a one-cycle valid strobe per request.
- Serves as the FPGA/emulation stand-in for external DRAM, connected directly to the accelerator core's dram_en_wr/dram_en_rd/addr/data pins.

---
 rtl/dram_responder.sv | 132 +++++++++++++
 tb/tb_dram_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: memory side of the accelerator DRAM read/write interface.
// Single-ported-per-direction word memory with one write and one read accepted
// per cycle. Read data returns after a fixed READ_LATENCY with a one-cycle
// valid strobe. Out-of-range accesses set the sticky err_oob flag.
// Optional build macro: DRAM_RESP_STATS_EN adds rd_count / wr_count outputs
// counting accepted in-range reads and writes.
module dram_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 18,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_oob
`ifdef DRAM_RESP_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Depth widened by one bit so the range check sees every address bit and
    // never aliases high addresses onto implemented words.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
            $error("dram_responder: READ_LATENCY must be in 1..8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    assign wr_in_range = ({1'b0, addr_wr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, addr_rd} < DEPTH_EXT);
    assign wr_idx      = addr_wr[IDX_W-1:0];
    assign rd_idx      = addr_rd[IDX_W-1:0];

    // Read word seen at the issue edge; out-of-range reads return zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_idx];
        end
    end

    // Memory array write port; the read above samples the pre-write contents.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents survive rst and map to plain RAM.
        if (en_wr && wr_in_range) begin
            mem[wr_idx] <= data_in;
        end
    end

    // Latency pipeline: stage 0 captures the issue, later stages shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage shifts from last-cycle values.
            pipe_valid[0] <= en_rd;
            pipe_data[0]  <= en_rd ? rd_word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Output register: strobe valid, update data_out only on returned reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            valid <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) begin
                data_out <= pipe_data[READ_LATENCY-1];
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oob <= 1'b0;
        end else if ((en_wr && !wr_in_range) || (en_rd && !rd_in_range)) begin
            err_oob <= 1'b1;
        end
    end

`ifdef DRAM_RESP_STATS_EN
    // Accepted in-range access counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (en_rd && rd_in_range) begin
                rd_count <= rd_count + 32'd1;
            end
            if (en_wr && wr_in_range) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Directed testbench for dram_responder (default parameters, READ_LATENCY=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dram_responder;

    localparam int DW = 32;
    localparam int AW = 18;

    logic          clk;
    logic          rst;
    logic          en_wr;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_in;
    logic          en_rd;
    logic [AW-1:0] addr_rd;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          err_oob;
`ifdef DRAM_RESP_STATS_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    int vectors;
    int miscompares;

    dram_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (4096),
        .READ_LATENCY(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_wr   (en_wr),
        .addr_wr (addr_wr),
        .data_in (data_in),
        .en_rd   (en_rd),
        .addr_rd (addr_rd),
        .valid   (valid),
        .data_out(data_out),
        .err_oob (err_oob)
`ifdef DRAM_RESP_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d vectors so far", vectors);
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        en_wr = 1'b1; addr_wr = a; data_in = d;
        cycle();
        en_wr = 1'b0;
    endtask

    // Issues one read; returns just after the issue edge.
    task automatic issue_read(input logic [AW-1:0] a);
        en_rd = 1'b1; addr_rd = a;
        cycle();
        en_rd = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #4;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_wr = 1'b0; en_rd = 1'b0;
        addr_wr = '0; addr_rd = '0; data_in = '0;
        cycle();
        cycle();
        vectors++;
        if (valid !== 1'b0 || data_out !== 32'h0 || err_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data_out=%h err_oob=%b, want 0/0/0", valid, data_out, err_oob);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic_rw();
        do_write(18'd5, 32'hDEADBEEF);
        issue_read(18'd5);                       // post issue edge
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early0: valid=%b want 0", valid);
        end
        cycle();                                 // one cycle after issue
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early1: valid=%b want 0", valid);
        end
        cycle();                                 // two cycles after issue
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_return: valid=%b data_out=%h want 1/deadbeef", valid, data_out);
        end
        cycle();
        vectors++;
        if (valid !== 1'b0 || data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_after: valid=%b data_out=%h want 0/deadbeef", valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            do_write(AW'(i), 32'h10 + DW'(i));
        end
        for (int k = 0; k < 8; k++) begin
            en_rd   = (k < 4);
            addr_rd = AW'(k);
            cycle();
            exp_v = (k >= 2 && k <= 5);
            exp_d = (k < 2) ? 32'hDEADBEEF : (k <= 5 ? 32'h10 + DW'(k - 2) : 32'h13);
            vectors++;
            if (valid !== exp_v || data_out !== exp_d) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: valid=%b data_out=%h want %b/%h", k, valid, data_out, exp_v, exp_d);
            end
        end
        en_rd = 1'b0;
    endtask

    task automatic test_collision();
        do_write(18'd7, 32'h1111);
        en_wr = 1'b1; addr_wr = 18'd7; data_in = 32'hAAAA;
        en_rd = 1'b1; addr_rd = 18'd7;
        cycle();
        en_wr = 1'b0;
        cycle();                                 // second read issued
        en_rd = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_early: valid=%b want 0", valid);
        end
        cycle();
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'h1111) begin
            miscompares++;
            $display("FAIL coll_old: valid=%b data_out=%h want 1/00001111", valid, data_out);
        end
        cycle();
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'hAAAA) begin
            miscompares++;
            $display("FAIL coll_new: valid=%b data_out=%h want 1/0000aaaa", valid, data_out);
        end
        cycle();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_after: valid=%b want 0", valid);
        end
    endtask

    task automatic test_oob_read();
        vectors++;
        if (err_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_pre: err_oob=%b want 0", err_oob);
        end
        issue_read(18'd4096);
        cycle();
        cycle();
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'h0 || err_oob !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_read: valid=%b data_out=%h err_oob=%b want 1/0/1", valid, data_out, err_oob);
        end
        repeat (4) cycle();
        vectors++;
        if (err_oob !== 1'b1 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_sticky: err_oob=%b valid=%b want 1/0", err_oob, valid);
        end
    endtask

    task automatic test_reset_in_flight();
        issue_read(18'd5);
        cycle();
        cycle();
        vectors++;
        if (data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rif_setup: data_out=%h want deadbeef", data_out);
        end
        en_rd = 1'b1; addr_rd = 18'd5;
        cycle();
        cycle();
        en_rd = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || data_out !== 32'h0 || err_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL rif_async_clear: valid=%b data_out=%h err_oob=%b want 0/0/0", valid, data_out, err_oob);
        end
        #3;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            vectors++;
            if (valid !== 1'b0 || data_out !== 32'h0) begin
                miscompares++;
                $display("FAIL rif_no_valid%0d: valid=%b data_out=%h want 0/0", k, valid, data_out);
            end
        end
        issue_read(18'd5);
        cycle();
        cycle();
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rif_mem_kept: valid=%b data_out=%h want 1/deadbeef", valid, data_out);
        end
    endtask

    task automatic test_oob_write();
        vectors++;
        if (err_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL oobw_pre: err_oob=%b want 0", err_oob);
        end
        do_write(18'd904, 32'h12345678);         // 5000 mod 4096 = 904
        do_write(18'd5000, 32'h00000BAD);
        vectors++;
        if (err_oob !== 1'b1) begin
            miscompares++;
            $display("FAIL oobw_flag: err_oob=%b want 1", err_oob);
        end
        issue_read(18'd904);
        cycle();
        cycle();
        vectors++;
        if (valid !== 1'b1 || data_out !== 32'h12345678) begin
            miscompares++;
            $display("FAIL oobw_no_alias: valid=%b data_out=%h want 1/12345678", valid, data_out);
        end
    endtask

`ifdef DRAM_RESP_STATS_EN
    task automatic test_stats();
        cycle();
        pulse_reset();
        cycle();
        for (int i = 0; i < 3; i++) begin
            do_write(AW'(20 + i), 32'h100 + DW'(i));
        end
        for (int i = 0; i < 5; i++) begin
            issue_read(AW'(20 + i));
        end
        issue_read(18'd70000);
        repeat (3) cycle();
        vectors++;
        if (wr_count !== 32'd3 || rd_count !== 32'd5) begin
            miscompares++;
            $display("FAIL stats_counts: wr_count=%0d rd_count=%0d want 3/5", wr_count, rd_count);
        end
        pulse_reset();
        cycle();
        vectors++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset: wr_count=%0d rd_count=%0d want 0/0", wr_count, rd_count);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_collision();
        test_oob_read();
        test_reset_in_flight();
        test_oob_write();
`ifdef DRAM_RESP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
